// File: rtl/radiometer_dicke_integrator_if.sv
// Result-frame handshake bundle for the Dicke radiometer integrator.
// The integrator drives the frame (master); the consumer returns out_ready (slave).
`timescale 1ns/1ps
interface radiometer_dicke_integrator_if #(
    parameter int NUM_CH = 2,
    parameter int ACC_W  = 40,
    parameter int CNT_W  = 24
);
    logic                    out_valid;
    logic                    out_ready;
    logic [NUM_CH*ACC_W-1:0] out_diff;
    logic [CNT_W-1:0]        out_n_ant;
    logic [CNT_W-1:0]        out_n_ref;

    modport master (
        output out_valid,
        output out_diff,
        output out_n_ant,
        output out_n_ref,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_diff,
        input  out_n_ant,
        input  out_n_ref,
        output out_ready
    );
endinterface

// File: rtl/radiometer_dicke_integrator.sv
// Dicke switch generator with blanking and NUM_CH-channel synchronous demodulating
// integrator; one antenna-minus-reference frame per INT_PERIODS switch periods.
`timescale 1ns/1ps
module radiometer_dicke_integrator #(
    parameter int NUM_CH      = 2,
    parameter int SAMPLE_W    = 12,
    parameter int HALF_PERIOD = 50000,
    parameter int BLANK       = 500,
    parameter int INT_PERIODS = 16,
    parameter int ACC_W       = 40,
    parameter int CNT_W       = 24
) (
    input  logic                         clk,
    input  logic                         clr,
    input  logic                         enable,
    input  logic                         sample_valid,
    input  logic [NUM_CH*SAMPLE_W-1:0]   sample_data,
    output logic                         switch_pwm,
    output logic                         overrun,
    radiometer_dicke_integrator_if.master res
);

    localparam int HW = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
    localparam int PW = (INT_PERIODS > 1) ? $clog2(INT_PERIODS) : 1;
    localparam logic [HW-1:0] HALF_LAST   = HW'(HALF_PERIOD - 1);
    localparam logic [HW-1:0] BLANK_END   = HW'(BLANK);
    localparam logic [PW-1:0] PERIOD_LAST = PW'(INT_PERIODS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ANT  = 2'd1,
        REF  = 2'd2
    } state_e;

    state_e                  state_q, state_d;
    logic [HW-1:0]           half_cnt_q, half_cnt_d;
    logic [PW-1:0]           period_cnt_q, period_cnt_d;
    logic                    pwm_q, pwm_d;
    logic                    frame_end;
    logic                    accept;
    logic                    clear_acc;

    logic signed [ACC_W-1:0] acc_q   [NUM_CH];
    logic signed [ACC_W-1:0] acc_sum [NUM_CH];
    logic signed [ACC_W-1:0] acc_d   [NUM_CH];
    logic [CNT_W-1:0]        n_ant_q, n_ant_sum, n_ant_d;
    logic [CNT_W-1:0]        n_ref_q, n_ref_sum, n_ref_d;

    logic                    out_valid_q, out_valid_d;
    logic                    overrun_q, overrun_d;
    logic [NUM_CH*ACC_W-1:0] out_diff_q, out_diff_d;
    logic [CNT_W-1:0]        out_n_ant_q, out_n_ant_d;
    logic [CNT_W-1:0]        out_n_ref_q, out_n_ref_d;

    function automatic logic signed [ACC_W-1:0] sext(input logic [SAMPLE_W-1:0] s);
        return {{(ACC_W-SAMPLE_W){s[SAMPLE_W-1]}}, s};
    endfunction

    // Switch sequencer: half-period counter, period counter, frame boundary.
    always_comb begin
        state_d      = state_q;
        half_cnt_d   = half_cnt_q;
        period_cnt_d = period_cnt_q;
        frame_end    = 1'b0;
        case (state_q)
            IDLE: begin
                half_cnt_d   = '0;
                period_cnt_d = '0;
                if (enable) state_d = ANT;
            end
            ANT: begin
                if (!enable) begin
                    state_d      = IDLE;
                    half_cnt_d   = '0;
                    period_cnt_d = '0;
                end else if (half_cnt_q == HALF_LAST) begin
                    state_d    = REF;
                    half_cnt_d = '0;
                end else begin
                    half_cnt_d = half_cnt_q + HW'(1);
                end
            end
            REF: begin
                if (!enable) begin
                    state_d      = IDLE;
                    half_cnt_d   = '0;
                    period_cnt_d = '0;
                end else if (half_cnt_q == HALF_LAST) begin
                    state_d    = ANT;
                    half_cnt_d = '0;
                    if (period_cnt_q == PERIOD_LAST) begin
                        frame_end    = 1'b1;
                        period_cnt_d = '0;
                    end else begin
                        period_cnt_d = period_cnt_q + PW'(1);
                    end
                end else begin
                    half_cnt_d = half_cnt_q + HW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        pwm_d = (state_d == ANT);
    end

    assign accept    = sample_valid && (state_q != IDLE) && (half_cnt_q >= BLANK_END);
    // Frame end hands acc_sum to the output and restarts from zero with no dead cycle.
    assign clear_acc = frame_end || (state_d == IDLE);

    always_comb begin
        n_ant_sum = n_ant_q;
        n_ref_sum = n_ref_q;
        for (int c = 0; c < NUM_CH; c++) begin
            acc_sum[c] = acc_q[c];
        end
        if (accept) begin
            if (state_q == ANT) begin
                for (int c = 0; c < NUM_CH; c++) begin
                    acc_sum[c] = acc_q[c] + sext(sample_data[c*SAMPLE_W +: SAMPLE_W]);
                end
                n_ant_sum = n_ant_q + CNT_W'(1);
            end else begin
                for (int c = 0; c < NUM_CH; c++) begin
                    acc_sum[c] = acc_q[c] - sext(sample_data[c*SAMPLE_W +: SAMPLE_W]);
                end
                n_ref_sum = n_ref_q + CNT_W'(1);
            end
        end
        for (int c = 0; c < NUM_CH; c++) begin
            acc_d[c] = clear_acc ? '0 : acc_sum[c];
        end
        n_ant_d = clear_acc ? '0 : n_ant_sum;
        n_ref_d = clear_acc ? '0 : n_ref_sum;
    end

    // Result register and handshake; a same-cycle ready consumes the old frame.
    always_comb begin
        out_valid_d = out_valid_q;
        overrun_d   = overrun_q;
        out_diff_d  = out_diff_q;
        out_n_ant_d = out_n_ant_q;
        out_n_ref_d = out_n_ref_q;
        if (frame_end) begin
            out_valid_d = 1'b1;
            if (out_valid_q && !res.out_ready) overrun_d = 1'b1;
            for (int c = 0; c < NUM_CH; c++) begin
                out_diff_d[c*ACC_W +: ACC_W] = acc_sum[c];
            end
            out_n_ant_d = n_ant_sum;
            out_n_ref_d = n_ref_sum;
        end else if (out_valid_q && res.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q      <= IDLE;
            half_cnt_q   <= '0;
            period_cnt_q <= '0;
            pwm_q        <= 1'b0;
            for (int c = 0; c < NUM_CH; c++) begin
                acc_q[c] <= '0;
            end
            n_ant_q      <= '0;
            n_ref_q      <= '0;
            out_valid_q  <= 1'b0;
            overrun_q    <= 1'b0;
            out_diff_q   <= '0;
            out_n_ant_q  <= '0;
            out_n_ref_q  <= '0;
        end else begin
            state_q      <= state_d;
            half_cnt_q   <= half_cnt_d;
            period_cnt_q <= period_cnt_d;
            pwm_q        <= pwm_d;
            for (int c = 0; c < NUM_CH; c++) begin
                acc_q[c] <= acc_d[c];
            end
            n_ant_q      <= n_ant_d;
            n_ref_q      <= n_ref_d;
            out_valid_q  <= out_valid_d;
            overrun_q    <= overrun_d;
            out_diff_q   <= out_diff_d;
            out_n_ant_q  <= out_n_ant_d;
            out_n_ref_q  <= out_n_ref_d;
        end
    end

    assign switch_pwm    = pwm_q;
    assign overrun       = overrun_q;
    assign res.out_valid = out_valid_q;
    assign res.out_diff  = out_diff_q;
    assign res.out_n_ant = out_n_ant_q;
    assign res.out_n_ref = out_n_ref_q;

endmodule

// File: tb/tb_radiometer_dicke_integrator.sv
// Scoreboard bench for radiometer_dicke_integrator: expected frames are queued as
// stimulus is set up and compared when the consumer accepts them.
`timescale 1ns/1ps
module tb_radiometer_dicke_integrator;

    localparam int NUM_CH      = 2;
    localparam int SAMPLE_W    = 8;
    localparam int HALF_PERIOD = 8;
    localparam int BLANK       = 2;
    localparam int INT_PERIODS = 2;
    localparam int ACC_W       = 16;
    localparam int CNT_W       = 8;

    logic                       clk = 1'b0;
    logic                       clr = 1'b0;
    logic                       enable = 1'b0;
    logic                       sample_valid = 1'b0;
    logic [NUM_CH*SAMPLE_W-1:0] sample_data = '0;
    logic                       switch_pwm;
    logic                       overrun;

    radiometer_dicke_integrator_if #(.NUM_CH(NUM_CH), .ACC_W(ACC_W), .CNT_W(CNT_W)) ifc ();

    radiometer_dicke_integrator #(
        .NUM_CH(NUM_CH), .SAMPLE_W(SAMPLE_W), .HALF_PERIOD(HALF_PERIOD), .BLANK(BLANK),
        .INT_PERIODS(INT_PERIODS), .ACC_W(ACC_W), .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .clr(clr),
        .enable(enable),
        .sample_valid(sample_valid),
        .sample_data(sample_data),
        .switch_pwm(switch_pwm),
        .overrun(overrun),
        .res(ifc)
    );

    always #5 clk = ~clk;

    typedef struct {
        int d0;
        int d1;
        int na;
        int nr;
    } frame_t;

    frame_t sb[$];
    int     n_vec  = 0;
    int     n_miss = 0;
    int     k      = 0;
    int     v_ant  = 0;
    int     v_ref  = 0;
    bit     blank_mode = 1'b0;
    bit     pwm_chk    = 1'b0;

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_vec++;
        if (obs != exp) begin
            n_miss++;
            $display("FAIL %s: observed %0d expected %0d (t=%0t k=%0d)", tag, obs, exp, $time, k);
        end
    endtask

    function automatic int diff_ch(input int c);
        logic signed [ACC_W-1:0] d;
        d = ifc.out_diff[c*ACC_W +: ACC_W];
        return int'(d);
    endfunction

    task automatic push(input int d0, input int d1, input int na, input int nr);
        frame_t f;
        f.d0 = d0; f.d1 = d1; f.na = na; f.nr = nr;
        sb.push_back(f);
    endtask

    // k counts cycles since enable was sampled; half_cnt = (k-1) % HALF_PERIOD.
    task automatic drive();
        logic signed [SAMPLE_W-1:0] s0, s1;
        sample_valid = blank_mode ? (((k - 1) % HALF_PERIOD) < BLANK) : 1'b1;
        s0 = switch_pwm ? SAMPLE_W'(v_ant) : SAMPLE_W'(v_ref);
        s1 = -8'sd3;
        sample_data = {s1, s0};
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        k++;
        if (pwm_chk) chk("pwm_phase", switch_pwm, (((k - 1) / HALF_PERIOD) % 2) == 0);
        drive();
    endtask

    task automatic wait_valid(input string tag, input int exp_k);
        int b;
        b = 0;
        while (!ifc.out_valid && b < 100) begin
            tick();
            b++;
        end
        chk(tag, k, exp_k);
    endtask

    always @(negedge clk) begin
        frame_t f;
        if (clr && ifc.out_valid && ifc.out_ready) begin
            chk("sb_pending", sb.size() > 0, 1);
            if (sb.size() > 0) begin
                f = sb.pop_front();
                chk("sb_diff0", diff_ch(0), f.d0);
                chk("sb_diff1", diff_ch(1), f.d1);
                chk("sb_n_ant", ifc.out_n_ant, f.na);
                chk("sb_n_ref", ifc.out_n_ref, f.nr);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset held with enable high and random samples.
        clr = 1'b0;
        enable = 1'b1;
        ifc.out_ready = 1'b1;
        repeat (4) begin
            @(posedge clk);
            #1;
            sample_valid = 1'b1;
            sample_data  = 16'($urandom);
        end
        chk("rst_pwm", switch_pwm, 0);
        chk("rst_valid", ifc.out_valid, 0);
        chk("rst_diff", ifc.out_diff, 0);
        chk("rst_n_ant", ifc.out_n_ant, 0);
        chk("rst_n_ref", ifc.out_n_ref, 0);
        chk("rst_overrun", overrun, 0);

        // Demodulation: ch0 10/4 by phase, ch1 constant -3.
        clr = 1'b1;
        k = 0; v_ant = 10; v_ref = 4;
        drive();
        chk("pwm_pre_enable", switch_pwm, 0);
        push(72, 0, 12, 12);
        pwm_chk = 1'b1;
        tick();
        chk("pwm_rise", switch_pwm, 1);
        wait_valid("demod_latency", 33);
        chk("demod_n_ant", ifc.out_n_ant, 12);
        chk("demod_diff0", diff_ch(0), 72);
        chk("demod_overrun", overrun, 0);

        // Blanking: samples only inside the blanking window.
        blank_mode = 1'b1;
        push(0, 0, 0, 0);
        push(0, 0, 0, 0);
        tick();
        chk("demod_valid_clear", ifc.out_valid, 0);
        while (k < 98) tick();
        chk("blank_drain", sb.size(), 0);

        // Back-pressure across two frames.
        pwm_chk = 1'b0;
        enable = 1'b0;
        blank_mode = 1'b0;
        tick();
        tick();
        ifc.out_ready = 1'b0;
        v_ant = 3; v_ref = 0;
        enable = 1'b1;
        k = 0;
        drive();
        pwm_chk = 1'b1;
        wait_valid("bp_first_latency", 33);
        chk("bp_first_diff0", diff_ch(0), 36);
        v_ant = 7;
        drive();
        while (k < 64) tick();
        chk("bp_no_overrun_yet", overrun, 0);
        chk("bp_hold_diff0", diff_ch(0), 36);
        tick();
        chk("bp_overrun", overrun, 1);
        chk("bp_valid", ifc.out_valid, 1);
        chk("bp_second_diff0", diff_ch(0), 84);
        chk("bp_second_diff1", diff_ch(1), 0);
        enable = 1'b0;
        pwm_chk = 1'b0;
        push(84, 0, 12, 12);
        ifc.out_ready = 1'b1;
        tick();
        ifc.out_ready = 1'b0;
        chk("bp_valid_clear", ifc.out_valid, 0);
        chk("bp_overrun_sticky", overrun, 1);

        // Abort at cycle 20, then a clean re-run.
        ifc.out_ready = 1'b1;
        v_ant = 10; v_ref = 4;
        enable = 1'b1;
        k = 0;
        drive();
        pwm_chk = 1'b1;
        while (k < 20) tick();
        enable = 1'b0;
        pwm_chk = 1'b0;
        tick();
        chk("abort_pwm", switch_pwm, 0);
        repeat (40) begin
            tick();
            chk("abort_no_valid", ifc.out_valid, 0);
        end
        enable = 1'b1;
        k = 0;
        drive();
        push(72, 0, 12, 12);
        pwm_chk = 1'b1;
        wait_valid("reenable_latency", 33);
        tick();
        chk("reenable_drain", sb.size(), 0);

        // Asynchronous reset pulse in a REF half-period.
        while (k < 44) tick();
        chk("pre_areset_pwm", switch_pwm, 0);
        chk("pre_areset_diff0", diff_ch(0), 72);
        chk("pre_areset_overrun", overrun, 1);
        #2;
        clr = 1'b0;
        #1;
        chk("areset_diff", ifc.out_diff, 0);
        chk("areset_n_ant", ifc.out_n_ant, 0);
        chk("areset_overrun", overrun, 0);
        chk("areset_valid", ifc.out_valid, 0);
        enable = 1'b0;
        pwm_chk = 1'b0;
        @(posedge clk);
        #1;
        clr = 1'b1;
        repeat (3) begin
            tick();
            chk("idle_hold_pwm", switch_pwm, 0);
        end
        enable = 1'b1;
        k = 0;
        tick();
        chk("restart_pwm", switch_pwm, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/radiometer_dicke_integrator.md
Name: radiometer_dicke_integrator

Overview:
- Parametrised successor to the fixed single-channel switch/ADC/demod chain.
- Generates the Dicke switch drive with a programmable half-period and a post-transition blanking window.
- Synchronously demodulates NUM_CH parallel signed sample streams by integrating antenna-phase sums minus reference-phase sums over INT_PERIODS switch periods.
- Presents one result frame per integration through a valid/ready handshake, and flags overruns.

Parameters:
NUM_CH, 2, number of parallel receiver channels
SAMPLE_W, 12, signed two's-complement sample width per channel
HALF_PERIOD, 50000, clk cycles per switch half-period (>= 2)
BLANK, 500, cycles at the start of each half-period whose samples are discarded (0 <= BLANK < HALF_PERIOD)
INT_PERIODS, 16, full switch periods (antenna+reference) per integration frame (>= 1)
ACC_W, 40, signed accumulator/result width per channel
CNT_W, 24, accepted-sample counter width

Ports:
clk  in  1  system clock
clr  in  1  asynchronous, active-low reset
enable  in  1  run request; low forces IDLE
sample_valid  in  1  all channels' samples valid this cycle
sample_data  in  NUM_CH*SAMPLE_W  packed signed samples, ch0 in LSBs
switch_pwm  out  1  Dicke switch drive: 1 = antenna phase, 0 = reference
out_valid  out  1  result frame available
out_ready  in  1  consumer accepts frame when out_valid&&out_ready
out_diff  out  NUM_CH*ACC_W  per-channel sum_ant - sum_ref, packed, ch0 in LSBs
out_n_ant  out  CNT_W  accepted antenna-phase sample events in frame
out_n_ref  out  CNT_W  accepted reference-phase sample events in frame
overrun  out  1  sticky: a completed frame overwrote an unconsumed one

Behaviour:
- Reset (clr=0, asynchronous): state IDLE, all counters/accumulators 0. switch_pwm=0, out_valid=0, out_diff=0, out_n_ant=0, out_n_ref=0, overrun=0.
- FSM states are IDLE, ANT and REF.
  - IDLE: when enable=1 is sampled, move to ANT next cycle with half_cnt=0, period_cnt=0, and cleared accumulators.
  - ANT: switch_pwm=1. When half_cnt=HALF_PERIOD-1, move to REF and set half_cnt to 0.
  - REF: switch_pwm=0. When half_cnt=HALF_PERIOD-1: if period_cnt=INT_PERIODS-1, the frame ends; set period_cnt to 0 and return to ANT. Otherwise increment period_cnt and return to ANT.
- switch_pwm is registered directly from the state, so it has no glitches.
- Acceptance: a sample event is accepted in ANT/REF when sample_valid=1 and half_cnt >= BLANK. Samples in IDLE or inside the blanking window are dropped.
- On an accepted event in ANT: each channel's accumulator adds its sign-extended sample, and n_ant increments. In REF: each accumulator subtracts its sample, and n_ref increments.
- Arithmetic wraps modulo 2^ACC_W and 2^CNT_W; there is no saturation. Sizing ACC_W is the integrator's responsibility.
- Frame end:
  - A sample accepted on the final REF cycle is included in the result.
  - On the next cycle, out_diff/out_n_ant/out_n_ref load the final values and out_valid=1.
  - Accumulators and counters restart from 0 on that same cycle, with no gap. If BLANK=0, a sample on that cycle goes into the new frame.
- Handshake:
  - The out_* data is held stable while out_valid=1 and out_ready=0.
  - out_valid clears on the cycle after out_valid&&out_ready.
  - If a new frame completes while out_valid=1 and out_ready=0, the new result overwrites the old one, out_valid stays 1, and overrun is set.
  - If out_ready=1 in the same cycle a new frame loads, the old frame counts as consumed, the new frame is presented, and overrun is not set.
  - overrun clears only on reset.
- enable=0 in ANT/REF: go to IDLE next cycle with switch_pwm=0. The partial frame is discarded and no out_valid is produced. An already-presented result is unaffected.
- Reset mid-frame: immediate return to reset values; the partial frame and any presented result are lost.
- Latency: with enable sampled high at cycle 0, ANT begins at cycle 1. The frame ends at cycle 2*HALF_PERIOD*INT_PERIODS, and out_valid rises one cycle later.

Test Plan:
All tests use NUM_CH=2, SAMPLE_W=8, HALF_PERIOD=8, BLANK=2, INT_PERIODS=2, ACC_W=16, CNT_W=8.
- Reset: hold clr=0 with enable=1 and random samples -> all outputs 0. Release clr -> switch_pwm rises 1 cycle after enable is sampled high.
- Demodulation: sample_valid=1 always; ch0=10 when switch_pwm=1 and 4 when 0; ch1=-3 constant; enable at cycle 0 -> at cycle 33, out_valid=1, out_n_ant=12, out_n_ref=12, out_diff ch0=72, ch1=0. switch_pwm toggles every 8 cycles.
- Blanking: sample_valid=1 only when half_cnt<2 -> every frame gives out_n_ant=0, out_n_ref=0, out_diff=0.
- Back-pressure: out_ready=0 across two frames with a different ch0 value per frame -> overrun=1, out_diff holds the second frame's values. Then out_ready=1 for one cycle -> out_valid=0 next cycle.
- Abort: drop enable at cycle 20 -> switch_pwm=0 at cycle 21 and no out_valid. Re-enable -> the first frame matches the Demodulation values exactly.
- Asynchronous reset: pulse clr=0 mid-cycle during REF -> outputs clear without waiting for a clk edge. Operation restarts only once clr=1 and enable=1.
